// File: rtl/vga_stream_out_pkg.sv
// Shared video definitions for the pixel path.
// Holds the default raster timing sets (640x480@60 and 1280x720@60),
// the RGB444 pixel type and a small helper to derive raster totals.
// Used by vga_stream_out, the frame-buffer fetch and the hdmi_interface glue.
package vga_stream_out_pkg;

    // 640x480@60, 25.175 MHz pixel clock
    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;

    // 1280x720@60, 74.25 MHz pixel clock (1650 x 750 total)
    localparam int unsigned HD_H_ACTIVE = 1280;
    localparam int unsigned HD_H_FP     = 110;
    localparam int unsigned HD_H_SYNC   = 40;
    localparam int unsigned HD_H_BP     = 220;
    localparam int unsigned HD_V_ACTIVE = 720;
    localparam int unsigned HD_V_FP     = 5;
    localparam int unsigned HD_V_SYNC   = 5;
    localparam int unsigned HD_V_BP     = 20;

    // RGB444 pixel, packed as {r[11:8], g[7:4], b[3:0]}
    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    // Total slots per line / lines per frame from the four timing regions.
    function automatic int unsigned timing_total(
        input int unsigned active,
        input int unsigned fp,
        input int unsigned sync,
        input int unsigned bp
    );
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_stream_out_counter.sv
// Free-running raster position counter (video_counter role).
// h_cnt counts pixel slots 0..H_TOTAL-1 every clock; v_cnt advances when
// h_cnt wraps and counts lines 0..V_TOTAL-1.
// Ports:
//   clk_pixel - pixel clock
//   reset     - synchronous, active-high; forces both counters to 0
//   h_cnt     - horizontal slot index
//   v_cnt     - line index
module vga_stream_out_counter #(
    parameter int unsigned H_TOTAL = 800,
    parameter int unsigned V_TOTAL = 525,
    localparam int HW = $clog2(H_TOTAL),
    localparam int VW = $clog2(V_TOTAL)
) (
    input  logic          clk_pixel,
    input  logic          reset,
    output logic [HW-1:0] h_cnt,
    output logic [VW-1:0] v_cnt
);

    localparam logic [HW-1:0] H_MAX = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_MAX = VW'(V_TOTAL - 1);

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_MAX) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_MAX) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/vga_stream_out.sv
// Streams RGB444 pixels onto a free-running VGA raster for hdmi_interface.
// Ports:
//   clk_pixel            - pixel clock (single clock domain)
//   reset                - synchronous, active-high
//   pix_data/pix_valid   - incoming pixel stream, {r,g,b} RGB444
//   pix_ready            - high in every active slot
//   frame_start          - pulse at the first active slot of a frame
//   line_start           - pulse at the first active slot of each active line
//   underflow_clr        - clears the sticky underflow flag
//   underflow            - sticky: an active slot found pix_valid low
//   vga_hsync/vsync/blank, vga_r/g/b - registered timing and colour
//
// Handshake: pix_ready is asserted combinationally in every active slot and
// never depends on pix_valid. A pixel is consumed in any cycle where both
// pix_ready and pix_valid are high. The raster never waits for the source:
// an active slot with pix_valid low is shown black and raises underflow.
module vga_stream_out
    import vga_stream_out_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned H_FP     = VGA_H_FP,
    parameter int unsigned H_SYNC   = VGA_H_SYNC,
    parameter int unsigned H_BP     = VGA_H_BP,
    parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
    parameter int unsigned V_FP     = VGA_V_FP,
    parameter int unsigned V_SYNC   = VGA_V_SYNC,
    parameter int unsigned V_BP     = VGA_V_BP,
    parameter logic        SYNC_POL = 1'b0
) (
    input  logic        clk_pixel,
    input  logic        reset,
    input  logic [11:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic        frame_start,
    output logic        line_start,
    input  logic        underflow_clr,
    output logic        underflow,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic        vga_blank,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b
);

    localparam int unsigned H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    // Region boundaries at counter width
    localparam logic [HW-1:0] H_ACT_END = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_START  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END    = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_ACT_END = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_START  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END    = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;

    logic    active;
    logic    hsync_on;
    logic    vsync_on;
    logic    miss;
    rgb444_t px;

    vga_stream_out_counter #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL)
    ) u_counter (
        .clk_pixel (clk_pixel),
        .reset     (reset),
        .h_cnt     (h_cnt),
        .v_cnt     (v_cnt)
    );

    always_comb begin
        active   = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
        hsync_on = (h_cnt >= HS_START) && (h_cnt < HS_END);
        vsync_on = (v_cnt >= VS_START) && (v_cnt < VS_END);
        px       = rgb444_t'(pix_data);
        miss     = active && !pix_valid;
    end

    // Strobes are gated with reset so nothing is offered while the raster
    // is being restarted.
    assign pix_ready   = active && !reset;
    assign frame_start = !reset && (h_cnt == '0) && (v_cnt == '0);
    assign line_start  = !reset && (h_cnt == '0) && (v_cnt < V_ACT_END);

    // All VGA outputs trail the counter state by one cycle.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            vga_blank <= 1'b1;
            vga_hsync <= ~SYNC_POL;
            vga_vsync <= ~SYNC_POL;
            vga_r     <= '0;
            vga_g     <= '0;
            vga_b     <= '0;
            underflow <= 1'b0;
        end else begin
            vga_blank <= ~active;
            vga_hsync <= hsync_on ? SYNC_POL : ~SYNC_POL;
            vga_vsync <= vsync_on ? SYNC_POL : ~SYNC_POL;
            if (active && pix_valid) begin
                vga_r <= px.r;
                vga_g <= px.g;
                vga_b <= px.b;
            end else begin
                vga_r <= '0;
                vga_g <= '0;
                vga_b <= '0;
            end
            // A fresh miss outranks a clear arriving in the same cycle.
            if (miss) begin
                underflow <= 1'b1;
            end else if (underflow_clr) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vga_stream_out.sv
// Bench for vga_stream_out on a reduced raster (16x6 active, 24x11 total)
// so several frames fit in a short run.
module tb_vga_stream_out;

    localparam int H_ACT = 16;
    localparam int H_FP  = 2;
    localparam int H_SY  = 3;
    localparam int H_BP  = 3;
    localparam int V_ACT = 6;
    localparam int V_FP  = 1;
    localparam int V_SY  = 2;
    localparam int V_BP  = 2;
    localparam int H_TOT = H_ACT + H_FP + H_SY + H_BP;   // 24
    localparam int V_TOT = V_ACT + V_FP + V_SY + V_BP;   // 11
    localparam int FRAME = H_TOT * V_TOT;                // 264
    localparam int ACT_SPAN = V_ACT * H_TOT;             // 144: cycles covering active lines
    localparam int HS_POS = H_ACT + H_FP;                // 18
    localparam int VS_POS = (V_ACT + V_FP) * H_TOT;      // 168

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [11:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        frame_start;
    logic        line_start;
    logic        underflow_clr;
    logic        underflow;
    logic        vga_hsync;
    logic        vga_vsync;
    logic        vga_blank;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;

    vga_stream_out #(
        .H_ACTIVE (H_ACT), .H_FP (H_FP), .H_SYNC (H_SY), .H_BP (H_BP),
        .V_ACTIVE (V_ACT), .V_FP (V_FP), .V_SYNC (V_SY), .V_BP (V_BP),
        .SYNC_POL (1'b0)
    ) dut (
        .clk_pixel     (clk),
        .reset         (reset),
        .pix_data      (pix_data),
        .pix_valid     (pix_valid),
        .pix_ready     (pix_ready),
        .frame_start   (frame_start),
        .line_start    (line_start),
        .underflow_clr (underflow_clr),
        .underflow     (underflow),
        .vga_hsync     (vga_hsync),
        .vga_vsync     (vga_vsync),
        .vga_blank     (vga_blank),
        .vga_r         (vga_r),
        .vga_g         (vga_g),
        .vga_b         (vga_b)
    );

    // scoreboard state
    logic [11:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    int   cyc      = 0;     // raster cycle index since last reset release
    int   run      = 0;     // 0 = first run, 1 = after mid-frame reset
    logic in_reset = 1'b1;

    int hs_count = 0;
    int ls_count = 0;
    int fs_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic valid_for(input int c, input int r);
        if (r != 0) return 1'b1;
        // one drop in blanking (must be ignored), three at pixel (5,2) of frame 1,
        // one at pixel (2,3) of frame 1 coinciding with a clear
        if (c == 20) return 1'b0;
        if (c >= 317 && c <= 319) return 1'b0;
        if (c == 338) return 1'b0;
        return 1'b1;
    endfunction

    // driver: one raster cycle per call, inputs applied at the falling edge
    task automatic step(input logic rst);
        int h;
        int fpos;
        @(negedge clk);
        if (rst) begin
            reset    = 1'b1;
            in_reset = 1'b1;
            exp_q.delete();
        end else begin
            if (in_reset) cyc = 0;
            else          cyc++;
            reset    = 1'b0;
            in_reset = 1'b0;
        end
        h    = cyc % H_TOT;
        fpos = cyc % FRAME;
        pix_valid     = rst ? 1'b1 : valid_for(cyc, run);
        pix_data      = (h == H_ACT - 1) ? 12'hF0A : 12'(cyc * 7 + 291);
        underflow_clr = !rst && (run == 0) && (cyc == 330 || cyc == 338 || cyc == 340);
        #1;
        if (rst) begin
            check("rst_pix_ready", pix_ready, 0);
            check("rst_frame_start", frame_start, 0);
            check("rst_line_start", line_start, 0);
        end else begin
            if (cyc == 0) check("release_pix_ready", pix_ready, 1);
            if (fpos == 0) check("frame_start_pos", frame_start, 1);
            if (h == H_ACT - 1 && fpos < ACT_SPAN) check("ready_last_px", pix_ready, 1);
            if (h == H_ACT && fpos < ACT_SPAN) check("ready_after_line", pix_ready, 0);
            if (run == 0 && cyc < FRAME) begin
                if (pix_ready && pix_valid) hs_count++;
                if (line_start) ls_count++;
                if (frame_start) fs_count++;
            end
            if (run == 0 && cyc == FRAME) begin
                check("frame_handshakes", hs_count, H_ACT * V_ACT);
                check("frame_line_starts", ls_count, V_ACT);
                check("frame_frame_starts", fs_count, 1);
            end
            if (pix_ready) exp_q.push_back(pix_valid ? pix_data : 12'h000);
        end
    endtask

    // monitor: samples registered outputs just after the rising edge
    logic prev_hs = 1'b1;
    logic prev_vs = 1'b1;
    int   hs_len  = 0;
    int   vs_len  = 0;

    always @(posedge clk) begin
        logic [11:0] exp_px;
        #1;
        if (in_reset) begin
            check("rst_blank", vga_blank, 1);
            check("rst_hsync", vga_hsync, 1);
            check("rst_vsync", vga_vsync, 1);
            check("rst_rgb", {vga_r, vga_g, vga_b}, 0);
            check("rst_underflow", underflow, 0);
            prev_hs = 1'b1;
            prev_vs = 1'b1;
            hs_len  = 0;
            vs_len  = 0;
        end else begin
            if (!vga_blank) begin
                if (exp_q.size() == 0) begin
                    check("sb_empty", 1, 0);
                end else begin
                    exp_px = exp_q.pop_front();
                    check("pixel", {vga_r, vga_g, vga_b}, exp_px);
                end
            end else begin
                check("blank_rgb", {vga_r, vga_g, vga_b}, 0);
            end
            if (cyc == 0) check("first_unblank", vga_blank, 0);
            if ((cyc % H_TOT) == H_ACT - 1 && (cyc % FRAME) < ACT_SPAN && valid_for(cyc, run)) begin
                check("last_px_r", vga_r, 4'hF);
                check("last_px_g", vga_g, 4'h0);
                check("last_px_b", vga_b, 4'hA);
            end
            // sync pulse placement and width
            if (prev_hs && !vga_hsync) begin
                check("hsync_pos", cyc % H_TOT, HS_POS);
                hs_len = 0;
            end
            if (!vga_hsync) hs_len++;
            if (!prev_hs && vga_hsync) check("hsync_width", hs_len, H_SY);
            if (prev_vs && !vga_vsync) begin
                check("vsync_pos", cyc % FRAME, VS_POS);
                vs_len = 0;
            end
            if (!vga_vsync) vs_len++;
            if (!prev_vs && vga_vsync) check("vsync_width", vs_len, V_SY * H_TOT);
            prev_hs = vga_hsync;
            prev_vs = vga_vsync;
            // sticky underflow sequence
            if (run == 0) begin
                case (cyc)
                    263: check("uf_blank_ignored", underflow, 0);
                    316: check("uf_before_drop", underflow, 0);
                    317: check("uf_set", underflow, 1);
                    329: check("uf_sticky", underflow, 1);
                    330: check("uf_cleared", underflow, 0);
                    338: check("uf_set_wins", underflow, 1);
                    339: check("uf_hold", underflow, 1);
                    340: check("uf_cleared2", underflow, 0);
                    default: ;
                endcase
            end
        end
    end

    initial begin
        reset         = 1'b1;
        pix_valid     = 1'b0;
        pix_data      = '0;
        underflow_clr = 1'b0;
        repeat (3) step(1'b1);
        // three frames of traffic, then reset at pixel (10,3) of frame 2
        step(1'b0);
        while (cyc < 2 * FRAME + 3 * H_TOT + 10 - 1) step(1'b0);
        step(1'b1);
        step(1'b1);
        run = 1;
        for (int i = 0; i < 300; i++) step(1'b0);
        @(posedge clk);
        #2;
        check("sb_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
